// File: rtl/mlp_train_scheduler_pkg.sv
// Shared types and constants for the MLP training scheduler.
package mlp_train_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_LOSS,
    S_UPDATE,
    S_EPOCH_END,
    S_DONE
  } sched_state_t;

  // Keeps ln() finite when the prediction saturates at 0.0 or 1.0.
  localparam real epsilon = 1.0e-7;

  // Address width for n samples; a single-sample set still gets one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_train_scheduler_if.sv
// Sample-store fetch handshake between the scheduler (master) and the store.
interface mlp_train_scheduler_if #(
  parameter int inputs  = 2,
  parameter int outputs = 1,
  parameter int addr_w  = 2
);
  logic              sample_req;
  logic [addr_w-1:0] sample_addr;
  logic              sample_valid;
  real               sample_values   [inputs];
  real               sample_expected [outputs];

  modport master (
    output sample_req, sample_addr,
    input  sample_valid, sample_values, sample_expected
  );

  modport slave (
    input  sample_req, sample_addr,
    output sample_valid, sample_values, sample_expected
  );
endinterface

// File: rtl/mlp_train_scheduler_bce_loss.sv
// Binary cross-entropy summed over all MLP outputs (combinational).
module bce_loss
  import mlp_train_scheduler_pkg::*;
#(
  parameter int outputs = 1
) (
  input  real prediction_i [outputs],
  input  real expected_i   [outputs],
  output real loss_o
);

  // Accumulate -[e*ln(p+eps) + (1-e)*ln(1-p+eps)] over every output.
  always_comb begin : sum_terms
    real acc;
    acc = 0.0;
    for (int o = 0; o < outputs; o++) begin
      acc = acc - (expected_i[o] * $ln(prediction_i[o] + epsilon)
                 + (1.0 - expected_i[o]) * $ln(1.0 - prediction_i[o] + epsilon));
    end
    loss_o = acc;
  end

endmodule

// File: rtl/mlp_train_scheduler.sv
// Epoch/sample sequencer that feeds an MLP, accumulates BCE loss and
// issues one-cycle training pulses with per-epoch learning-rate decay.
module mlp_train_scheduler
  import mlp_train_scheduler_pkg::*;
#(
  parameter int inputs        = 2,
  parameter int outputs       = 1,
  parameter int num_samples   = 4,
  parameter int settle_cycles = 2,
  parameter int epoch_w       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [epoch_w-1:0] num_epochs_i,
  input  real                base_learning_rate_i,
  input  real                lr_decay_i,
  mlp_train_scheduler_if.master store,
  output real                mlp_values_o   [inputs],
  output real                mlp_expected_o [outputs],
  output logic               mlp_training_o,
  output real                mlp_learning_rate_o,
  input  real                mlp_prediction_i [outputs],
  output real                epoch_loss_o,
  output logic [epoch_w-1:0] epoch_count_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int addr_w   = addr_width(num_samples);
  localparam int settle_w = $clog2(settle_cycles + 1);
  localparam logic [addr_w-1:0]   last_addr   = addr_w'(num_samples - 1);
  localparam logic [settle_w-1:0] settle_load = settle_w'(settle_cycles - 1);

  sched_state_t        state_q, state_d;
  logic [settle_w-1:0] settle_q;
  logic [addr_w-1:0]   addr_q;
  logic [epoch_w-1:0]  num_epochs_q, epoch_count_q, epoch_inc;
  real                 lr_decay_q, lr_q, running_loss_q, epoch_loss_q, loss_c;
  real                 values_q   [inputs];
  real                 expected_q [outputs];
  logic                sample_req_q, training_q, busy_q, done_q;

  assign epoch_inc = epoch_count_q + epoch_w'(1);

  bce_loss #(.outputs(outputs)) u_bce (
    .prediction_i (mlp_prediction_i),
    .expected_i   (expected_q),
    .loss_o       (loss_c)
  );

  // Next-state selection; abort overrides every transition outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_i) state_d = (num_epochs_i == '0) ? S_DONE : S_FETCH;
      S_FETCH:     if (store.sample_valid) state_d = S_SETTLE;
      S_SETTLE:    if (settle_q == '0) state_d = S_LOSS;
      S_LOSS:      state_d = S_UPDATE;
      S_UPDATE:    state_d = (addr_q == last_addr) ? S_EPOCH_END : S_FETCH;
      S_EPOCH_END: state_d = (epoch_inc == num_epochs_q) ? S_DONE : S_FETCH;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // State register; status outputs are decoded from the next state so they
  // are registered yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_req_q <= 1'b0;
      training_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_req_q <= (state_d == S_FETCH);
      training_q   <= (state_d == S_UPDATE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  // Datapath: run setup, sample latch, settle timer, loss and epoch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q       <= '0;
      addr_q         <= '0;
      num_epochs_q   <= '0;
      epoch_count_q  <= '0;
      lr_decay_q     <= 0.0;
      lr_q           <= 0.0;
      running_loss_q <= 0.0;
      epoch_loss_q   <= 0.0;
      for (int i = 0; i < inputs; i++)  values_q[i]   <= 0.0;
      for (int o = 0; o < outputs; o++) expected_q[o] <= 0.0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          num_epochs_q   <= num_epochs_i;
          lr_decay_q     <= lr_decay_i;
          lr_q           <= base_learning_rate_i;
          epoch_count_q  <= '0;
          running_loss_q <= 0.0;
          addr_q         <= '0;
        end
        S_FETCH: if (store.sample_valid && !abort_i) begin
          for (int i = 0; i < inputs; i++)  values_q[i]   <= store.sample_values[i];
          for (int o = 0; o < outputs; o++) expected_q[o] <= store.sample_expected[o];
          settle_q <= settle_load;
        end
        S_SETTLE: if (settle_q != '0) settle_q <= settle_q - settle_w'(1);
        S_LOSS:   if (!abort_i) running_loss_q <= running_loss_q + loss_c;
        S_UPDATE: if (!abort_i && (addr_q != last_addr)) addr_q <= addr_q + addr_w'(1);
        S_EPOCH_END: if (!abort_i) begin
          epoch_loss_q   <= running_loss_q;
          running_loss_q <= 0.0;
          epoch_count_q  <= epoch_inc;
          lr_q           <= lr_q * lr_decay_q;
          addr_q         <= '0;
        end
        default: ;
      endcase
    end
  end

  assign store.sample_req    = sample_req_q;
  assign store.sample_addr   = addr_q;
  assign mlp_values_o        = values_q;
  assign mlp_expected_o      = expected_q;
  assign mlp_training_o      = training_q;
  assign mlp_learning_rate_o = lr_q;
  assign epoch_loss_o        = epoch_loss_q;
  assign epoch_count_o       = epoch_count_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;

endmodule

// File: tb/tb_mlp_train_scheduler.sv
// Randomized self-checking bench for mlp_train_scheduler with a sample-store
// model, a stub MLP prediction and an epoch-level reference model.
module tb_mlp_train_scheduler;
  import mlp_train_scheduler_pkg::*;

  localparam int NS = 4;
  localparam int SC = 2;
  localparam int NI = 2;
  localparam int NO = 1;
  localparam int EW = 16;
  localparam int AW = 2;
  localparam real EPS = 1.0e-7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [EW-1:0] num_epochs = '0;
  real           base_lr = 0.0;
  real           lr_decay = 0.0;
  real           mlp_values [NI];
  real           mlp_expected [NO];
  real           mlp_prediction [NO];
  logic          mlp_training;
  real           mlp_lr;
  real           epoch_loss;
  logic [EW-1:0] epoch_count;
  logic          busy, done;

  mlp_train_scheduler_if #(.inputs(NI), .outputs(NO), .addr_w(AW)) store_if ();

  mlp_train_scheduler #(
    .inputs(NI), .outputs(NO), .num_samples(NS), .settle_cycles(SC), .epoch_w(EW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_i              (start),
    .abort_i              (abort),
    .num_epochs_i         (num_epochs),
    .base_learning_rate_i (base_lr),
    .lr_decay_i           (lr_decay),
    .store                (store_if),
    .mlp_values_o         (mlp_values),
    .mlp_expected_o       (mlp_expected),
    .mlp_training_o       (mlp_training),
    .mlp_learning_rate_o  (mlp_lr),
    .mlp_prediction_i     (mlp_prediction),
    .epoch_loss_o         (epoch_loss),
    .epoch_count_o        (epoch_count),
    .busy_o               (busy),
    .done_o               (done)
  );

  real tv [NS][NI];
  real te [NS];
  int  wait_tab [NS];
  bit  pred_half = 1'b0;

  // Stub MLP: either a fixed 0.5 or a prediction equal to the first feature.
  always_comb mlp_prediction[0] = pred_half ? 0.5 : mlp_values[0];

  int  n_checks = 0;
  int  n_errors = 0;
  real model_v0 = 0.0, model_loss = 0.0, model_lr = 0.0;
  int  model_cnt = 0;

  task automatic chk(input string tag, input real got, input real exp);
    real diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > 1.0e-5 * (1.0 + ((exp < 0.0) ? -exp : exp))) begin
      n_errors++;
      $display("FAIL %s: got %f expected %f", tag, got, exp);
    end
  endtask

  function automatic real bce(input real p, input real e);
    return -(e * $ln(p + EPS) + (1.0 - e) * $ln(1.0 - p + EPS));
  endfunction

  task automatic set_tables(input bit half, input int wmode);
    pred_half = half;
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < NI; i++) tv[s][i] = $urandom_range(5, 95) / 100.0;
      te[s] = half ? 1.0 : real'($urandom_range(0, 1));
      case (wmode)
        1:       wait_tab[s] = (s == 2) ? 3 : 0;
        2:       wait_tab[s] = int'($urandom_range(0, 2));
        default: wait_tab[s] = 0;
      endcase
    end
  endtask

  task automatic run_case(input string name, input int ne, input real blr,
                          input real dec, input int abort_ep);
    int  cyc = 0, busy_n = 0, run_n = 0, done_n = 0, req_n = 0, trn_n = 0;
    int  rise_n = 0, req_len = 0, wait_cnt = 0, idx, ep, waits_sum = 0, completed;
    bit  prev_req = 0, prev_trn = 0, fin = 0, aborted = 0;
    real ep_loss = 0.0, lr_e;
    for (int s = 0; s < NS; s++) begin
      ep_loss   += bce(pred_half ? 0.5 : tv[s][0], te[s]);
      waits_sum += wait_tab[s];
    end
    num_epochs = EW'(ne);
    base_lr    = blr;
    lr_decay   = dec;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 4000) begin
      if (abort) begin
        abort = 1'b0;
        chk({name, " abort busy"}, busy, 0);
        chk({name, " abort done"}, done, 0);
        chk({name, " abort training"}, mlp_training, 0);
        fin = 1;
      end else begin
        if (busy) busy_n++;
        if (busy && !done) run_n++;
        if (done) begin done_n++; fin = 1; end
        if (mlp_training) begin
          trn_n++;
          if (!prev_trn) rise_n++;
          idx  = (rise_n - 1) % NS;
          ep   = (rise_n - 1) / NS;
          lr_e = blr;
          for (int e = 0; e < ep; e++) lr_e = lr_e * dec;
          chk({name, " lr"}, mlp_lr, lr_e);
          chk({name, " values"}, mlp_values[0], tv[idx][0]);
          chk({name, " expected"}, mlp_expected[0], te[idx]);
          if (abort_ep >= 0 && ep == abort_ep && !aborted) begin
            abort   = 1'b1;
            aborted = 1;
          end
        end
      end
      if (store_if.sample_req) begin
        idx = rise_n % NS;
        if (!prev_req) begin wait_cnt = wait_tab[idx]; req_len = 0; end
        req_len++;
        req_n++;
        chk({name, " addr"}, store_if.sample_addr, idx);
        chk({name, " values hold"}, mlp_values[0], model_v0);
        if (wait_cnt == 0) begin
          store_if.sample_valid = 1'b1;
          for (int i = 0; i < NI; i++) store_if.sample_values[i] = tv[idx][i];
          store_if.sample_expected[0] = te[idx];
          chk({name, " req len"}, req_len, wait_tab[idx] + 1);
          model_v0 = tv[idx][0];
        end else begin
          store_if.sample_valid = 1'b0;
          for (int i = 0; i < NI; i++) store_if.sample_values[i] = 7.0;
          store_if.sample_expected[0] = 0.25;
          wait_cnt--;
        end
      end else begin
        store_if.sample_valid = 1'($urandom_range(0, 1));
        for (int i = 0; i < NI; i++) store_if.sample_values[i] = 9.0;
        store_if.sample_expected[0] = 0.75;
      end
      prev_req = store_if.sample_req;
      prev_trn = mlp_training;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) chk({name, " timeout"}, 1, 0);
    completed = aborted ? abort_ep : ne;
    if (completed > 0) model_loss = ep_loss;
    model_cnt = completed;
    model_lr  = blr;
    for (int e = 0; e < completed; e++) model_lr = model_lr * dec;
    chk({name, " idle busy"}, busy, 0);
    chk({name, " idle done"}, done, 0);
    chk({name, " epoch_count"}, epoch_count, model_cnt);
    chk({name, " epoch_loss"}, epoch_loss, model_loss);
    chk({name, " final lr"}, mlp_lr, model_lr);
    chk({name, " idle values"}, mlp_values[0], model_v0);
    if (aborted) begin
      chk({name, " no done"}, done_n, 0);
    end else begin
      chk({name, " training cycles"}, trn_n, ne * NS);
      chk({name, " training pulses"}, rise_n, ne * NS);
      chk({name, " run cycles"}, run_n, ne * (NS * (SC + 3) + 1) + ne * waits_sum);
      chk({name, " busy cycles"}, busy_n, run_n + 1);
      chk({name, " req cycles"}, req_n, ne * (NS + waits_sum));
    end
  endtask

  initial begin
    store_if.sample_valid = 1'b0;
    for (int i = 0; i < NI; i++) store_if.sample_values[i] = 0.0;
    store_if.sample_expected[0] = 0.0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst req", store_if.sample_req, 0);
    chk("rst training", mlp_training, 0);
    chk("rst addr", store_if.sample_addr, 0);
    chk("rst epoch_count", epoch_count, 0);
    chk("rst epoch_loss", epoch_loss, 0.0);
    chk("rst lr", mlp_lr, 0.0);
    chk("rst values0", mlp_values[0], 0.0);
    chk("rst values1", mlp_values[1], 0.0);
    chk("rst expected", mlp_expected[0], 0.0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_tables(1'b0, 0);
    run_case("main", 3, 0.5, 0.9, -1);

    run_case("zero", 0, 0.3, 0.7, -1);

    set_tables(1'b1, 1);
    run_case("ln2", 2, 0.5, 0.5, -1);
    chk("ln2 loss const", epoch_loss, 2.7725887);
    chk("ln2 lr const", mlp_lr, 0.125);

    set_tables(1'b0, 0);
    run_case("abort", 3, $urandom_range(10, 90) / 100.0, $urandom_range(50, 99) / 100.0, 1);
    run_case("restart", 1, 0.4, 0.8, -1);

    for (int k = 0; k < 3; k++) begin
      set_tables(1'b0, 2);
      run_case("rand", int'($urandom_range(1, 3)), $urandom_range(10, 90) / 100.0,
               $urandom_range(50, 99) / 100.0, -1);
    end

    // Reset in the middle of a run.
    set_tables(1'b0, 0);
    num_epochs = EW'(2);
    base_lr    = 0.6;
    lr_decay   = 0.5;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    store_if.sample_valid = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst req", store_if.sample_req, 0);
    chk("midrst epoch_count", epoch_count, 0);
    chk("midrst lr", mlp_lr, 0.0);
    chk("midrst values", mlp_values[0], 0.0);
    rst = 1'b0;
    model_v0   = 0.0;
    model_loss = 0.0;
    store_if.sample_valid = 1'b0;
    @(posedge clk); #1;
    run_case("post_rst", 1, 0.2, 0.5, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
